// File: rtl/sdram_responder.sv
// SDRAM device-side responder: command decode, per-bank row tracking, x16 storage, CL-delayed read data.
// Optional refresh-interval watchdog is compiled in with SDRAM_RESP_REFRESH_CHECK_EN.
module sdram_responder #(
  parameter int ROW_WIDTH     = 13,
  parameter int COL_WIDTH     = 9,
  parameter int BANK_WIDTH    = 2,
  parameter int SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
  parameter int MEM_ROW_BITS  = 4,
  parameter int TRCD          = 2,
  parameter int REFRESH_LIMIT = 1100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SDRADDR_WIDTH-1:0]     addr,
  input  logic [BANK_WIDTH-1:0]        bank_addr,
  inout  wire  [15:0]                  data,
  input  logic                         clock_enable,
  input  logic                         cs_n,
  input  logic                         ras_n,
  input  logic                         cas_n,
  input  logic                         we_n,
  input  logic                         data_mask_low,
  input  logic                         data_mask_high,
  output logic                         init_done,
  output logic [(1<<BANK_WIDTH)-1:0]   open_banks,
  output logic                         cmd_err,
  output logic [2:0]                   err_code
);

  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam int MEM_AW    = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;
  localparam int TRCD_W    = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam logic [TRCD_W-1:0] TRCD_LOAD = TRCD_W'((TRCD > 0) ? TRCD - 1 : 0);

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  logic [15:0]          mem [0:(1<<MEM_AW)-1];
  logic [ROW_WIDTH-1:0] row_q [NUM_BANKS];
  logic [TRCD_W-1:0]    trcd_cnt [NUM_BANKS];
  logic                 cl3;
  logic [2:0]           pipe_vld;
  logic [15:0]          pipe_dat [3];

  logic              cmd_vld, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic              bank_open, trcd_ok, mrs_legal, dq_drive, cmd_ok, do_rd, do_wr;
  logic              ref_over;
  logic [2:0]        err_now, err_any;
  logic [MEM_AW-1:0] mem_idx;
  logic              unused_row_hi;

  assign cmd_vld = clock_enable & ~cs_n;
  assign is_act  = cmd_vld && ({ras_n, cas_n, we_n} == CMD_ACT);
  assign is_rd   = cmd_vld && ({ras_n, cas_n, we_n} == CMD_RD);
  assign is_wr   = cmd_vld && ({ras_n, cas_n, we_n} == CMD_WR);
  assign is_pre  = cmd_vld && ({ras_n, cas_n, we_n} == CMD_PRE);
  assign is_ref  = cmd_vld && ({ras_n, cas_n, we_n} == CMD_REF);
  assign is_mrs  = cmd_vld && ({ras_n, cas_n, we_n} == CMD_MRS);

  assign bank_open = open_banks[bank_addr];
  assign trcd_ok   = (trcd_cnt[bank_addr] == '0);
  assign mrs_legal = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
  assign mem_idx   = {bank_addr, row_q[bank_addr][MEM_ROW_BITS-1:0], addr[COL_WIDTH-1:0]};
  assign dq_drive  = pipe_vld[0];
  assign data      = dq_drive ? pipe_dat[0] : 16'hzzzz;

  // Only the low row bits address storage; the full row is kept for tracking.
  always_comb begin
    unused_row_hi = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) unused_row_hi ^= ^row_q[b][ROW_WIDTH-1:MEM_ROW_BITS];
  end

  // REF is accepted before init_done: the power-up sequence refreshes ahead of MRS.
  always_comb begin
    err_now = 3'd0;
    if (is_act) begin
      if (!init_done)     err_now = 3'd1;
      else if (bank_open) err_now = 3'd2;
    end else if (is_rd || is_wr) begin
      if (!init_done)            err_now = 3'd1;
      else if (!bank_open)       err_now = 3'd3;
      else if (!trcd_ok)         err_now = 3'd4;
      else if (is_wr && dq_drive) err_now = 3'd7;
    end else if (is_ref) begin
      if (|open_banks) err_now = 3'd6;
    end else if (is_mrs) begin
      if (|open_banks)     err_now = 3'd6;
      else if (!mrs_legal) err_now = 3'd5;
    end
  end

  assign cmd_ok  = (err_now == 3'd0);
  assign do_rd   = is_rd & cmd_ok;
  assign do_wr   = is_wr & cmd_ok;
  assign err_any = (err_now != 3'd0) ? err_now : (ref_over ? 3'd6 : 3'd0);

`ifdef SDRAM_RESP_REFRESH_CHECK_EN
  logic [15:0] ref_cnt;

  assign ref_over = init_done && !(is_ref && cmd_ok) &&
                    (({16'd0, ref_cnt} + 32'd1) > 32'(REFRESH_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (init_done) begin
      if (is_ref && cmd_ok)      ref_cnt <= '0;
      else if (ref_cnt != '1)    ref_cnt <= ref_cnt + 16'd1;
    end
  end
`else
  assign ref_over = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done  <= 1'b0;
      open_banks <= '0;
      cmd_err    <= 1'b0;
      err_code   <= 3'd0;
      cl3        <= 1'b1;
      pipe_vld   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b]    <= '0;
        trcd_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;

      if (is_act && cmd_ok) begin
        open_banks[bank_addr] <= 1'b1;
        row_q[bank_addr]      <= addr[ROW_WIDTH-1:0];
        trcd_cnt[bank_addr]   <= TRCD_LOAD;
      end
      if ((do_rd || do_wr) && addr[10]) open_banks[bank_addr] <= 1'b0;
      if (is_pre) begin
        if (addr[10]) open_banks <= '0;
        else          open_banks[bank_addr] <= 1'b0;
      end
      if (is_mrs && cmd_ok) begin
        init_done <= 1'b1;
        cl3       <= addr[4];
      end

      // Slot k drives DQ after k more edges; a read enters at slot CL-1.
      pipe_vld[0] <= pipe_vld[1];
      pipe_vld[1] <= (do_rd && !cl3) ? 1'b1 : pipe_vld[2];
      pipe_vld[2] <= do_rd && cl3;

      if (!cmd_err && (err_any != 3'd0)) begin
        cmd_err  <= 1'b1;
        err_code <= err_any;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      if (!data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
      if (!data_mask_high) mem[mem_idx][15:8] <= data[15:8];
    end
    pipe_dat[0] <= pipe_dat[1];
    pipe_dat[1] <= (do_rd && !cl3) ? mem[mem_idx] : pipe_dat[2];
    pipe_dat[2] <= mem[mem_idx];
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder against a cycle-stamped behavioural memory model.
`timescale 1ns/100ps
module tb_sdram_responder;
  localparam int LIMIT   = 50;
  localparam int TRCD_TB = 2;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [12:0] addr = '0;
  logic [1:0]  bank_addr = '0;
  logic clock_enable = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic data_mask_low = 1'b0, data_mask_high = 1'b0;
  logic init_done, cmd_err;
  logic [3:0] open_banks;
  logic [2:0] err_code;
  wire  [15:0] data;
  logic [15:0] tb_dq = '0;
  logic tb_dq_en = 1'b0;

  assign data = tb_dq_en ? tb_dq : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data[i]);
  end

  sdram_responder #(.REFRESH_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bank_addr(bank_addr), .data(data),
    .clock_enable(clock_enable), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
    .init_done(init_done), .open_banks(open_banks), .cmd_err(cmd_err), .err_code(err_code));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;

  // reference state
  bit          init_m, err_m;
  bit [3:0]    open_m;
  logic [12:0] row_m [4];
  int          act_m [4];
  int          cl_m, ref_base;
  logic [2:0]  code_m;
  logic [15:0] mem_m [int];
  logic [15:0] exp_dq [int];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int mkey(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
    return int'({b, r[3:0], c});
  endfunction

  task automatic reset_model();
    init_m = 0; err_m = 0; open_m = '0; code_m = '0; cl_m = 3; ref_base = 0;
    exp_dq.delete();
  endtask

  task automatic check_outputs();
    check_val("init_done", init_done, init_m);
    check_val("open_banks", open_banks, open_m);
    check_val("cmd_err", cmd_err, err_m);
    check_val("err_code", err_code, code_m);
    if (exp_dq.exists(cyc)) check_val("dq_data", data, exp_dq[cyc]);
    else                    check_val("dq_z", data, 16'hFFFF);
  endtask

  task automatic model(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] wd, input logic ml, input logic mh, input bit vld);
    int n = cyc;
    int e = 0;
    bit rerr = 0;
    int k = mkey(ba, row_m[ba], a[8:0]);
    logic [15:0] old;
    if (vld) begin
      case (c)
        C_ACT: if (!init_m) e = 1; else if (open_m[ba]) e = 2;
        C_RD, C_WR: begin
          if (!init_m)                               e = 1;
          else if (!open_m[ba])                      e = 3;
          else if (n - act_m[ba] < TRCD_TB)          e = 4;
          else if (c == C_WR && exp_dq.exists(n - 1)) e = 7;
        end
        C_REF: if (open_m != 0) e = 6;
        C_MRS: begin
          if (open_m != 0) e = 6;
          else if (!((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'b000)) e = 5;
        end
        default: ;
      endcase
    end
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
    if (init_m && !(vld && c == C_REF && e == 0) && (n - ref_base) > LIMIT) rerr = 1;
`endif
    if (vld && e == 0) begin
      case (c)
        C_ACT: begin open_m[ba] = 1; row_m[ba] = a; act_m[ba] = n; end
        C_RD: begin
          if (mem_m.exists(k)) exp_dq[n + cl_m - 1] = mem_m[k];
          if (a[10]) open_m[ba] = 0;
        end
        C_WR: begin
          old = mem_m.exists(k) ? mem_m[k] : 16'h0000;
          mem_m[k] = {mh ? old[15:8] : wd[15:8], ml ? old[7:0] : wd[7:0]};
          if (a[10]) open_m[ba] = 0;
        end
        C_PRE: if (a[10]) open_m = '0; else open_m[ba] = 0;
        C_REF: ref_base = n;
        C_MRS: begin
          if (!init_m) ref_base = n;
          init_m = 1; cl_m = int'(a[6:4]);
        end
        default: ;
      endcase
    end
    if (!err_m && e != 0)   begin err_m = 1; code_m = 3'(e); end
    else if (!err_m && rerr) begin err_m = 1; code_m = 3'd6; end
  endtask

  task automatic step(input logic [2:0] c, input logic [1:0] ba = 0, input logic [12:0] a = 0,
                      input logic [15:0] wd = 0, input logic ml = 0, input logic mh = 0,
                      input logic cs = 0, input logic cke = 1);
    @(negedge clk);
    {ras_n, cas_n, we_n} = c; cs_n = cs; clock_enable = cke;
    bank_addr = ba; addr = a; data_mask_low = ml; data_mask_high = mh;
    tb_dq = wd; tb_dq_en = (c == C_WR);
    @(posedge clk);
    #1;
    model(c, ba, a, wd, ml, mh, !cs && cke);
    tb_dq_en = 0;
    #1;
    check_outputs();
  endtask

  task automatic reset_dut();
    rst_n = 0; cs_n = 1; clock_enable = 1; {ras_n, cas_n, we_n} = C_NOP; tb_dq_en = 0;
    #1;
    reset_model();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic do_init();
    step(C_PRE, 0, 13'h400);
    step(C_REF);
    step(C_REF);
    step(C_MRS, 0, 13'h230);
  endtask

  task automatic rand_phase(input int nsteps);
    logic [12:0] mrs_tab [5];
    mrs_tab[0] = 13'h020; mrs_tab[1] = 13'h030; mrs_tab[2] = 13'h230;
    mrs_tab[3] = 13'h040; mrs_tab[4] = 13'h031;
    for (int i = 0; i < nsteps; i++) begin
      int r = $urandom_range(0, 99);
      logic [1:0]  ba  = 2'($urandom_range(0, 3));
      logic [12:0] row = {8'd0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      logic [8:0]  col = 9'($urandom_range(0, 7));
      logic        a10 = ($urandom_range(0, 3) == 0);
      logic [15:0] wd  = 16'($urandom);
      int          k   = mkey(ba, row_m[ba], col);
      bool_sel: begin end
      if (r < 8)       step(3'($urandom), ba, 13'($urandom), wd, 0, 0, 1'b1, 1'b1);
      else if (r < 12) step(3'($urandom), ba, 13'($urandom), wd, 0, 0, 1'b0, 1'b0);
      else if (r < 27) step(C_ACT, ba, row);
      else if (r < 72) begin
        if (r < 50 && mem_m.exists(k)) step(C_RD, ba, {2'b00, a10, 1'b0, col});
        else if (mem_m.exists(k))
          step(C_WR, ba, {2'b00, a10, 1'b0, col}, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else step(C_WR, ba, {2'b00, a10, 1'b0, col}, wd);
      end
      else if (r < 82) step(C_PRE, ba, {2'b00, a10, 10'd0});
      else if (r < 92) step(C_REF);
      else             step(C_MRS, 0, mrs_tab[$urandom_range(0, 4)]);
    end
  endtask

  initial begin
    reset_model();
    #2;
    reset_dut();

    do_init();
    check_val("tp_init_done", init_done, 1);
    check_val("tp_init_noerr", cmd_err, 0);

    step(C_ACT, 1, 13'h005); step(C_NOP);
    step(C_WR, 1, 13'h412, 16'hBEEF);
    step(C_ACT, 1, 13'h005); step(C_NOP);
    step(C_RD, 1, 13'h412); step(C_NOP); step(C_NOP);
    check_val("tp_rd_beef", data, 16'hBEEF);
    step(C_NOP);
    check_val("tp_rd_z", data, 16'hFFFF);
    check_val("tp_autopre", open_banks, 0);

    step(C_ACT, 2, 13'h003); step(C_NOP);
    step(C_WR, 2, 13'h020, 16'h1234);
    step(C_WR, 2, 13'h020, 16'hABCD, 0, 1);
    step(C_RD, 2, 13'h020); step(C_NOP); step(C_NOP);
    check_val("tp_masked", data, 16'h12CD);
    step(C_PRE, 0, 13'h400); step(C_NOP);

    step(C_MRS, 0, 13'h020);
    step(C_ACT, 2, 13'h003); step(C_NOP);
    step(C_WR, 2, 13'h021, 16'h5A5A);
    step(C_RD, 2, 13'h020); step(C_RD, 2, 13'h021);
    check_val("tp_cl2_first", data, 16'h12CD);
    step(C_NOP);
    check_val("tp_cl2_second", data, 16'h5A5A);
    step(C_NOP);
    check_val("tp_cl2_z", data, 16'hFFFF);

    step(C_RD, 2, 13'h020); step(C_NOP);
    step(C_WR, 2, 13'h020, 16'h0000);
    check_val("tp_contention", {cmd_err, err_code}, {1'b1, 3'd7});
    step(C_RD, 2, 13'h020); step(C_NOP);
    check_val("tp_contention_nowr", data, 16'h12CD);

    reset_dut(); do_init();
    step(C_MRS, 0, 13'h031);
    check_val("tp_bad_mrs", {cmd_err, err_code}, {1'b1, 3'd5});
    check_val("tp_bad_mrs_init", init_done, 1);

    reset_dut();
    step(C_ACT, 0, 13'h001);
    check_val("tp_act_preinit", {cmd_err, err_code}, {1'b1, 3'd1});

    reset_dut(); do_init();
    step(C_ACT, 0, 13'h001); step(C_RD, 0, 13'h000);
    check_val("tp_trcd", {cmd_err, err_code}, {1'b1, 3'd4});

    reset_dut(); do_init();
    step(C_ACT, 3, 13'h001); step(C_ACT, 3, 13'h002);
    check_val("tp_act_open", {cmd_err, err_code}, {1'b1, 3'd2});

    reset_dut(); do_init();
    step(C_RD, 0, 13'h000);
    check_val("tp_rd_closed", {cmd_err, err_code}, {1'b1, 3'd3});

    reset_dut(); do_init();
    step(C_ACT, 0, 13'h001); step(C_REF);
    check_val("tp_ref_open", {cmd_err, err_code}, {1'b1, 3'd6});

    reset_dut(); do_init();
    step(C_ACT, 1, 13'h005); step(C_NOP);
    step(C_RD, 1, 13'h012); step(C_NOP); step(C_NOP);
    check_val("tp_midrd_drive", data, 16'hBEEF);
    reset_dut();
    check_val("tp_midrd_banks", open_banks, 0);

    do_init();
    repeat (LIMIT) step(C_NOP);
    check_val("tp_ref_limit_ok", cmd_err, 0);
    step(C_NOP);
`ifdef SDRAM_RESP_REFRESH_CHECK_EN
    check_val("tp_ref_overdue", {cmd_err, err_code}, {1'b1, 3'd6});
`else
    check_val("tp_ref_nocheck", cmd_err, 0);
`endif

    for (int p = 0; p < 4; p++) begin
      reset_dut();
      do_init();
      rand_phase(150);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
